// File: rtl/ex_operand_stage.sv
// ex_operand_stage: resolves operand forwarding, builds ALU A/B and presents them through a 2-entry skid buffer.
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_rs_addr_i,
    input  logic [4:0]        in_rt_addr_i,
    input  logic [DATA_W-1:0] in_rs_data_i,
    input  logic [DATA_W-1:0] in_rt_data_i,
    input  logic [4:0]        in_shamt_i,
    input  logic              in_a_shamt_i,
    input  logic [5:0]        in_alufun_i,
    input  logic [4:0]        in_wr_addr_i,
    input  logic              exmem_wr_en_i,
    input  logic [4:0]        exmem_wr_addr_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_wr_en_i,
    input  logic [4:0]        memwb_wr_addr_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic [5:0]        out_alufun_o,
    output logic [4:0]        out_wr_addr_o
);
    localparam int PW = 2*DATA_W + 11;
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [PW-1:0]     main_q, main_d, skid_q, skid_d, in_pkt;
    logic [DATA_W-1:0] fwd_rs, fwd_rt, op_a;
    logic              acc, drain, main_load_skid, main_load_new, skid_load_new;
    // $0 is hardwired zero in the register file, so a producer targeting it is ignored
    always_comb begin
        fwd_rs = (!FWD_EN || in_rs_addr_i == 5'd0) ? in_rs_data_i :
                 (exmem_wr_en_i && exmem_wr_addr_i == in_rs_addr_i) ? exmem_result_i :
                 (memwb_wr_en_i && memwb_wr_addr_i == in_rs_addr_i) ? memwb_result_i : in_rs_data_i;
        fwd_rt = (!FWD_EN || in_rt_addr_i == 5'd0) ? in_rt_data_i :
                 (exmem_wr_en_i && exmem_wr_addr_i == in_rt_addr_i) ? exmem_result_i :
                 (memwb_wr_en_i && memwb_wr_addr_i == in_rt_addr_i) ? memwb_result_i : in_rt_data_i;
        op_a   = in_a_shamt_i ? {{(DATA_W-5){1'b0}}, in_shamt_i} : fwd_rs;
        in_pkt = {op_a, fwd_rt, in_alufun_i, in_wr_addr_i};
    end
    assign in_ready_o = ~skid_valid_q & ~reset_i;
    assign acc        = in_valid_i & in_ready_o;
    assign drain      = main_valid_q & out_ready_i;
    always_comb begin
        main_load_skid = drain & skid_valid_q;
        main_load_new  = acc & (~main_valid_q | (drain & ~skid_valid_q));
        skid_load_new  = acc & ~main_load_new;
        main_valid_d   = flush_i ? 1'b0 : (main_load_skid | main_load_new | (main_valid_q & ~drain));
        skid_valid_d   = flush_i ? 1'b0 : (skid_load_new | (skid_valid_q & ~drain));
        main_d         = main_load_skid ? skid_q : main_load_new ? in_pkt : main_q;
        skid_d         = skid_load_new ? in_pkt : skid_q;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end
    assign out_valid_o = main_valid_q;
    assign {out_a_o, out_b_o, out_alufun_o, out_wr_addr_o} = main_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed vectors with a queue scoreboard and an independent output monitor.
module tb_ex_operand_stage;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [4:0]  rs_addr = '0, rt_addr = '0, shamt = '0, wr_addr = '0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        a_shamt = 1'b0;
    logic [5:0]  alufun = '0;
    logic        ex_en = 1'b0, mw_en = 1'b0;
    logic [4:0]  ex_addr = '0, mw_addr = '0;
    logic [31:0] ex_res = '0, mw_res = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_a, out_b;
    logic [5:0]  out_alufun;
    logic [4:0]  out_wr_addr;
    int          n_vec = 0, n_bad = 0;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fun;
        logic [4:0]  wr;
    } exp_t;
    exp_t q[$];

    ex_operand_stage #(.DATA_W(32), .FWD_EN(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs_addr_i(rs_addr), .in_rt_addr_i(rt_addr), .in_rs_data_i(rs_data), .in_rt_data_i(rt_data),
        .in_shamt_i(shamt), .in_a_shamt_i(a_shamt), .in_alufun_i(alufun), .in_wr_addr_i(wr_addr),
        .exmem_wr_en_i(ex_en), .exmem_wr_addr_i(ex_addr), .exmem_result_i(ex_res),
        .memwb_wr_en_i(mw_en), .memwb_wr_addr_i(mw_addr), .memwb_result_i(mw_res),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_a_o(out_a), .out_b_o(out_b), .out_alufun_o(out_alufun), .out_wr_addr_o(out_wr_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [4:0] sh, input logic ash,
                        input logic [5:0] fun, input logic [4:0] wr,
                        input logic [31:0] ea, input logic [31:0] eb);
        logic rdy;
        rs_addr = rs; rt_addr = rt; rs_data = rsd; rt_data = rtd;
        shamt = sh; a_shamt = ash; alufun = fun; wr_addr = wr; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                q.push_back('{a: ea, b: eb, fun: fun, wr: wr});
                #1 in_valid = 1'b0;
                return;
            end
            #1;
        end
        chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("out_a", {32'd0, out_a}, {32'd0, e.a});
                    chk("out_b", {32'd0, out_b}, {32'd0, e.b});
                    chk("out_alufun", {58'd0, out_alufun}, {58'd0, e.fun});
                    chk("out_wr_addr", {59'd0, out_wr_addr}, {59'd0, e.wr});
                end
            end
        end
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_a", {32'd0, out_a}, 64'd0);
        chk("rst_out_b", {32'd0, out_b}, 64'd0);
        chk("rst_fun_wr", {53'd0, out_alufun, out_wr_addr}, 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        // sll $9, $8, 4
        send(5'd0, 5'd8, 32'h0, 32'h0000_00F1, 5'd4, 1'b1, 6'b100000, 5'd9, 32'h4, 32'hF1);
        @(negedge clk);
        chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
        step();
        // srav with both stages matching rs: EX/MEM wins
        ex_en = 1; ex_addr = 5'd3; ex_res = 32'h1F; mw_en = 1; mw_addr = 5'd3; mw_res = 32'h2;
        send(5'd3, 5'd4, 32'h55, 32'h8000_0000, 5'd0, 1'b0, 6'b100011, 5'd10, 32'h1F, 32'h8000_0000);
        // MEM/WB forwards rs, EX/MEM forwards rt
        ex_addr = 5'd6; ex_res = 32'h999; mw_addr = 5'd5; mw_res = 32'h1234;
        send(5'd5, 5'd6, 32'h11, 32'h7, 5'd0, 1'b0, 6'b100001, 5'd11, 32'h1234, 32'h999);
        // $0 is never forwarded
        ex_addr = 5'd0; ex_res = 32'hDEAD; mw_addr = 5'd0; mw_res = 32'hBEEF;
        send(5'd0, 5'd0, 32'hABC, 32'h5, 5'd0, 1'b0, 6'b100000, 5'd12, 32'hABC, 32'h5);
        // matching address but write enables low
        ex_en = 0; mw_en = 0; ex_addr = 5'd7; mw_addr = 5'd7;
        send(5'd7, 5'd7, 32'h70, 32'h71, 5'd0, 1'b0, 6'b100010, 5'd13, 32'h70, 32'h71);
        // shamt path ignores a forwarded rs; rt still forwarded
        ex_en = 1; ex_addr = 5'd2; ex_res = 32'hCAFE;
        send(5'd2, 5'd2, 32'h1, 32'h2, 5'd31, 1'b1, 6'b100011, 5'd14, 32'h1F, 32'hCAFE);
        ex_en = 0;
        repeat (3) step();
        // back-pressure: out_ready low for 3 cycles while streaming 4 ops
        out_ready = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(5'd1, 5'd2, 32'h101, 32'h201, 5'd0, 1'b0, 6'b000000, 5'd21, 32'h101, 32'h201);
                send(5'd1, 5'd2, 32'h102, 32'h202, 5'd0, 1'b0, 6'b000001, 5'd22, 32'h102, 32'h202);
                chk("bp_in_ready_drop", {63'd0, in_ready}, 64'd0);
                chk("bp_hold_a", {32'd0, out_a}, 64'h101);
                send(5'd1, 5'd2, 32'h103, 32'h203, 5'd0, 1'b0, 6'b000011, 5'd23, 32'h103, 32'h203);
                send(5'd1, 5'd2, 32'h104, 32'h204, 5'd0, 1'b0, 6'b000000, 5'd24, 32'h104, 32'h204);
            end
        join
        repeat (4) step();
        chk("bp_all_out", q.size(), 64'd0);
        // flush with skid full and in_valid high
        out_ready = 1'b0;
        send(5'd1, 5'd2, 32'hA1, 32'hA2, 5'd0, 1'b0, 6'b000000, 5'd1, 32'hA1, 32'hA2);
        send(5'd1, 5'd2, 32'hB1, 32'hB2, 5'd0, 1'b0, 6'b000000, 5'd2, 32'hB1, 32'hB2);
        rs_data = 32'hC1; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        out_ready = 1'b1;
        repeat (2) step();
        send(5'd1, 5'd2, 32'hD1, 32'hD2, 5'd0, 1'b0, 6'b000001, 5'd4, 32'hD1, 32'hD2);
        repeat (2) step();
        // flush beats a simultaneous accept into an empty stage
        rs_data = 32'hE1; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_accept", {63'd0, out_valid}, 64'd0);
        step();
        // reset mid-stall discards both held entries
        out_ready = 1'b0;
        send(5'd1, 5'd2, 32'hF1, 32'hF2, 5'd0, 1'b0, 6'b000000, 5'd5, 32'hF1, 32'hF2);
        send(5'd1, 5'd2, 32'hF3, 32'hF4, 5'd0, 1'b0, 6'b000000, 5'd6, 32'hF3, 32'hF4);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_a", {32'd0, out_a}, 64'd0);
        step();
        reset = 1'b0;
        q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready_after", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_out_valid_after", {63'd0, out_valid}, 64'd0);
        step();
        send(5'd9, 5'd0, 32'h9, 32'h3, 5'd2, 1'b1, 6'b000001, 5'd7, 32'h2, 32'h3);
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        chk("final_drain", q.size(), 64'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
